// File: rtl/bus_transfer_ctrl_pkg.sv
// Purpose : shared definitions for the bus transfer sequencer and the future
//           microcode sequencer: state encoding, default widths and a helper
//           telling whether a state has a source driving the data bus.
// Ports   : none (package).
package bus_transfer_ctrl_pkg;

    localparam int unsigned BTC_DATA_WIDTH  = 16;
    localparam int unsigned BTC_NUM_REGS    = 8;
    localparam int unsigned BTC_SEL_WIDTH   = 3;
    localparam int unsigned BTC_STATE_WIDTH = 3;

    typedef enum logic [BTC_STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } xfer_state_t;

    // The source driver is on from DRIVE through RELEASE (settle, load, hold).
    function automatic logic drives_bus(input xfer_state_t s);
        return (s == ST_DRIVE) || (s == ST_LOAD) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/bus_transfer_ctrl_sel_decoder.sv
// Purpose : one-hot decoder with enable; all outputs zero when disabled.
// Ports   : i_en        - decode enable
//           i_sel       - binary select
//           o_onehot_c  - combinational one-hot result (NUM_OUT bits)
module sel_decoder
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OUT   = BTC_NUM_REGS,
    parameter int unsigned SEL_WIDTH = BTC_SEL_WIDTH
) (
    input  logic                 i_en,
    input  logic [SEL_WIDTH-1:0] i_sel,
    output logic [NUM_OUT-1:0]   o_onehot_c
);

    // Selects at or beyond NUM_OUT decode to all zeros.
    always_comb begin
        o_onehot_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (i_en && (i_sel == SEL_WIDTH'(i))) begin
                o_onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Purpose : sequences one word move between bank registers (or from an
//           immediate) over the shared tristate bus: DRIVE -> LOAD -> RELEASE,
//           with a driver-free IDLE cycle between transfers.
// Ports   : clock, reset                - clock, synchronous active-high reset
//           req_valid/req_ready         - request handshake (ready only in IDLE)
//           req_src/req_dst/req_imm_en/req_imm - request payload, latched on accept
//           reg_oe                      - per-register output enable (one-hot or 0)
//           reg_notLoad                 - per-register load strobe, active low
//           bus_out/bus_oe              - immediate value and its bus enable
//           done/err                    - completion / rejection pulses
module bus_transfer_ctrl
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BTC_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = BTC_NUM_REGS,
    parameter int unsigned SEL_WIDTH  = BTC_SEL_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_WIDTH-1:0]  req_src,
    input  logic [SEL_WIDTH-1:0]  req_dst,
    input  logic                  req_imm_en,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic [NUM_REGS-1:0]   reg_oe,
    output logic [NUM_REGS-1:0]   reg_notLoad,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  done,
    output logic                  err
);

    xfer_state_t           r_state;
    xfer_state_t           w_state_nxt;
    logic [SEL_WIDTH-1:0]  r_src, r_dst, w_src_nxt, w_dst_nxt;
    logic                  r_imm_en, w_imm_en_nxt;
    logic [DATA_WIDTH-1:0] r_imm, w_imm_nxt;
    logic                  r_req_ready;
    logic [NUM_REGS-1:0]   r_reg_oe, r_reg_notload;
    logic                  r_bus_oe, r_done, r_err;
    logic                  w_accept, w_sel_ok;
    logic                  w_oe_en, w_ld_en;
    logic [NUM_REGS-1:0]   w_oe_dec, w_ld_dec;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;
    assign w_sel_ok = (32'(req_dst) < NUM_REGS) &&
                      (req_imm_en || (32'(req_src) < NUM_REGS));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next latched request.
    always_comb begin
        w_state_nxt  = r_state;
        w_src_nxt    = r_src;
        w_dst_nxt    = r_dst;
        w_imm_en_nxt = r_imm_en;
        w_imm_nxt    = r_imm;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_src_nxt    = req_src;
                    w_dst_nxt    = req_dst;
                    w_imm_en_nxt = req_imm_en;
                    w_imm_nxt    = req_imm;
                    w_state_nxt  = w_sel_ok ? ST_DRIVE : ST_ERR;
                end
            end
            ST_DRIVE:   w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            ST_ERR:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the output registers line up
    // with the state they describe.
    assign w_oe_en = drives_bus(w_state_nxt) && !w_imm_en_nxt;
    assign w_ld_en = (w_state_nxt == ST_LOAD);

    sel_decoder #(
        .NUM_OUT   (NUM_REGS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_oe_dec (
        .i_en       (w_oe_en),
        .i_sel      (w_src_nxt),
        .o_onehot_c (w_oe_dec)
    );

    sel_decoder #(
        .NUM_OUT   (NUM_REGS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_ld_dec (
        .i_en       (w_ld_en),
        .i_sel      (w_dst_nxt),
        .o_onehot_c (w_ld_dec)
    );

    // Latched request and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src         <= '0;
            r_dst         <= '0;
            r_imm_en      <= 1'b0;
            r_imm         <= '0;
            r_req_ready   <= 1'b0;
            r_reg_oe      <= '0;
            r_reg_notload <= '1;
            r_bus_oe      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_src         <= w_src_nxt;
            r_dst         <= w_dst_nxt;
            r_imm_en      <= w_imm_en_nxt;
            r_imm         <= w_imm_nxt;
            r_req_ready   <= (w_state_nxt == ST_IDLE);
            r_reg_oe      <= w_oe_dec;
            r_reg_notload <= ~w_ld_dec;
            r_bus_oe      <= drives_bus(w_state_nxt) && w_imm_en_nxt;
            r_done        <= (w_state_nxt == ST_RELEASE);
            r_err         <= (w_state_nxt == ST_ERR);
        end
    end

    assign req_ready   = r_req_ready;
    assign reg_oe      = r_reg_oe;
    assign reg_notLoad = r_reg_notload;
    assign bus_out     = r_imm;
    assign bus_oe      = r_bus_oe;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench: controller plus a behavioural register bank on a shared bus,
// scoreboard of expected transfers checked by an independent monitor.
module tb_bus_transfer_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 6;
    localparam int unsigned SW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_src = '0;
    logic [SW-1:0] req_dst = '0;
    logic          req_imm_en = 1'b0;
    logic [DW-1:0] req_imm = '0;
    logic [NR-1:0] reg_oe;
    logic [NR-1:0] reg_notLoad;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          done;
    logic          err;

    bus_transfer_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SEL_WIDTH  (SW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_imm_en  (req_imm_en),
        .req_imm     (req_imm),
        .reg_oe      (reg_oe),
        .reg_notLoad (reg_notLoad),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            is_err;
        int            src;
        int            dst;
        bit            imm_en;
        logic [DW-1:0] imm;
        logic [DW-1:0] val;
        int            acc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            rst_q = 1'b0;
    bit            b2b = 1'b0;
    int            last_done = -1;
    int            last_ok_acc = -100;
    logic [DW-1:0] ref_bank [NR] = '{default: '0};
    logic [DW-1:0] bank [NR];
    logic [DW-1:0] bus_val;
    int            ndrv;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Resolved bus and the register bank it feeds.
    always_comb begin
        bus_val = '0;
        ndrv    = 0;
        if (bus_oe) begin
            bus_val = bus_out;
            ndrv    = ndrv + 1;
        end
        for (int i = 0; i < NR; i++) begin
            if (reg_oe[i]) begin
                bus_val = bank[i];
                ndrv    = ndrv + 1;
            end
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < NR; i++) begin
            if (!reg_notLoad[i]) bank[i] <= bus_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t cyc=%0d actual=%0h required=%0h", name, $time, cyc, act, req);
        end
    endtask

    // Monitor: per-cycle strobes against the scoreboard head.
    always @(negedge clock) begin : mon
        int            d;
        bit            have;
        exp_t          e;
        logic [NR-1:0] e_oe;
        logic [NR-1:0] e_nl;
        bit            e_boe, e_done, e_err, e_rdy;
        if (cyc > 0) begin
            chk("single_driver", 32'(ndrv > 1), 32'(0));
            chk("single_load", 32'($countones(~reg_notLoad) > 1), 32'(0));
            if (rst_q) begin
                q.delete();
                chk("rst_req_ready", 32'(req_ready), 32'(0));
                chk("rst_reg_oe", 32'(reg_oe), 32'(0));
                chk("rst_reg_notLoad", 32'(reg_notLoad), 32'({NR{1'b1}}));
                chk("rst_bus_oe", 32'(bus_oe), 32'(0));
                chk("rst_bus_out", 32'(bus_out), 32'(0));
                chk("rst_done", 32'(done), 32'(0));
                chk("rst_err", 32'(err), 32'(0));
            end else begin
                have = (q.size() != 0);
                d    = 0;
                if (have) begin
                    e = q[0];
                    d = cyc - e.acc;
                end
                e_oe  = '0;
                e_nl  = '1;
                e_boe = 1'b0;
                if (have && !e.is_err && d >= 1 && d <= 3) begin
                    if (e.imm_en) e_boe = 1'b1;
                    else          e_oe  = NR'(1) << e.src;
                end
                if (have && !e.is_err && d == 2) e_nl = ~(NR'(1) << e.dst);
                e_done = have && !e.is_err && d == 3;
                e_err  = have && e.is_err && d == 1;
                e_rdy  = !have || d == 0;
                chk("req_ready", 32'(req_ready), 32'(e_rdy));
                chk("reg_oe", 32'(reg_oe), 32'(e_oe));
                chk("reg_notLoad", 32'(reg_notLoad), 32'(e_nl));
                chk("bus_oe", 32'(bus_oe), 32'(e_boe));
                chk("done", 32'(done), 32'(e_done));
                chk("err", 32'(err), 32'(e_err));
                if (e_boe) chk("bus_out", 32'(bus_out), 32'(e.imm));
                if (e_done) chk($sformatf("r%0d_value", e.dst), 32'(bank[e.dst]), 32'(e.val));
                if (done && b2b) begin
                    if (last_done >= 0) chk("done_spacing", 32'(cyc - last_done), 32'(4));
                    last_done = cyc;
                end
                if (have && ((e.is_err && d >= 1) || (!e.is_err && d >= 3))) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of stimulus; on acceptance, predict the result.
    task automatic send(input bit v, input int s, input int d, input bit ie, input logic [DW-1:0] im);
        exp_t e;
        req_valid  = v;
        req_src    = SW'(s);
        req_dst    = SW'(d);
        req_imm_en = ie;
        req_imm    = im;
        @(negedge clock);
        if (v && req_ready && !reset) begin
            e.is_err = !(d < NR && (ie || s < NR));
            e.src    = s;
            e.dst    = d;
            e.imm_en = ie;
            e.imm    = im;
            e.acc    = cyc;
            e.val    = '0;
            if (!e.is_err) begin
                e.val       = ie ? im : ref_bank[s];
                ref_bank[d] = e.val;
            end
            if (last_ok_acc >= 0) chk("accept_gap", 32'(cyc - last_ok_acc >= 4), 32'(1));
            last_ok_acc = e.is_err ? -100 : cyc;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clock);
            ok = (q.size() == 0) && req_ready;
            @(posedge clock);
            #1;
        end
        if (!ok) chk("idle_timeout_pending", 32'(q.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] old4;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Immediate load, register copy, self copy.
        send(1, 0, 2, 1, 16'hF0F0);
        wait_idle();
        chk("r2_imm", 32'(bank[2]), 32'h0000_F0F0);
        send(1, 2, 5, 0, 16'h0000);
        wait_idle();
        chk("r5_copy", 32'(bank[5]), 32'h0000_F0F0);
        send(1, 0, 0, 1, 16'h1111); wait_idle();
        send(1, 0, 1, 1, 16'h2222); wait_idle();
        send(1, 0, 3, 1, 16'h1234); wait_idle();
        send(1, 0, 4, 1, 16'h4444); wait_idle();
        send(1, 3, 3, 0, 16'h0000);
        wait_idle();
        chk("r3_self", 32'(bank[3]), 32'h0000_1234);

        // Rejected selects, and an out-of-range src ignored for an immediate.
        send(1, 0, 7, 1, 16'hDEAD); wait_idle();
        send(1, 6, 0, 0, 16'h0000); wait_idle();
        send(1, 7, 1, 1, 16'hBEEF); wait_idle();

        // Back-to-back with req_valid held high.
        b2b       = 1'b1;
        last_done = -1;
        for (int i = 0; i < 40; i++) begin
            send(1, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                 bit'($urandom_range(0, 1)), DW'($urandom));
        end
        b2b = 1'b0;
        wait_idle();

        // Random traffic, including invalid selects and requests mid-transfer.
        for (int i = 0; i < 400; i++) begin
            send(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), DW'($urandom));
        end
        wait_idle();

        // Reset while in LOAD.
        old4 = ref_bank[4];
        send(1, 0, 4, 1, 16'hA5A5);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        last_ok_acc = -100;
        @(posedge clock);
        #1;
        chk("r4_after_abort", 32'(bank[4] == old4 || bank[4] == 16'hA5A5), 32'(1));
        ref_bank[4] = bank[4];
        send(1, 4, 0, 0, 16'h0000);
        wait_idle();

        chk("scoreboard_drained", 32'(q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
